// File: rtl/inst_issue.sv
// Instruction issue unit: a host fills a circular instruction queue, then a
// run pulse makes the issuer hand the queued instructions one at a time to a
// consumer. Each instruction is held valid until the consumer acknowledges it.
// The issuer then waits for execution to finish before presenting the next one.
// When the queue runs dry after an execution, a single prog_done pulse marks
// the end of the program.
module inst_issue #(
    parameter int INST_WIDTH = 27,
    parameter int DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_wr_en,
    input  logic [INST_WIDTH-1:0]  host_wr_inst,
    input  logic                   run_start,
    input  logic                   abort,
    output logic [INST_WIDTH-1:0]  inst,
    output logic                   inst_valid,
    input  logic                   inst_ack,
    input  logic                   exec_done,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   prog_done,
    output logic                   overflow
);

    // Pointer width; DEPTH is a power of two, so pointers wrap for free.
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    // Issuer states
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_EXEC = 2'd2;
    localparam logic [1:0] FINISH    = 2'd3;

    logic [INST_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  load_issue;
    logic                  push_ok;
    logic                  pop;
    logic [AW:0]           count_next;
    logic [INST_WIDTH-1:0] head;

    // Status outputs come straight from registers, so no input reaches an output.
    assign full = (count == CNT_FULL);
    assign busy = (state != IDLE);
    assign head = mem[rd_ptr];

    // A push is taken in any state unless the queue is full or an abort drops it.
    assign push_ok = host_wr_en && !full && !abort;

    // The head leaves the queue only when the consumer acknowledges a valid word.
    assign pop = (state == ISSUE) && inst_valid && inst_ack;

    // Occupancy after this cycle; a simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push_ok) begin
            count_next = count - CNT_ONE;
        end
    end

    // Next-state logic; branch decisions use the occupancy before any push this cycle.
    always_comb begin
        state_next = state;
        load_issue = 1'b0;
        case (state)
            IDLE: begin
                if (run_start) begin
                    if (count != '0) begin
                        state_next = ISSUE;
                        load_issue = 1'b1;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            ISSUE: begin
                if (pop) begin
                    state_next = WAIT_EXEC;
                end
            end
            WAIT_EXEC: begin
                if (exec_done) begin
                    if (count != '0) begin
                        state_next = ISSUE;
                        load_issue = 1'b1;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Queue storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= host_wr_inst;
        end
    end

    // State register; reset and abort both park the issuer in IDLE.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Queue pointers and occupancy; reset and abort empty the queue.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // Issue register; only reset clears inst, abort just drops valid and keeps the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst       <= '0;
            inst_valid <= 1'b0;
        end else if (abort) begin
            inst_valid <= 1'b0;
        end else if (load_issue) begin
            inst       <= head;
            inst_valid <= 1'b1;
        end else if (pop) begin
            inst_valid <= 1'b0;
        end
    end

    // Sticky overflow and the one-cycle completion pulse leaving FINISH.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            overflow  <= 1'b0;
            prog_done <= 1'b0;
        end else begin
            if (host_wr_en && full) begin
                overflow <= 1'b1;
            end
            prog_done <= (state == FINISH);
        end
    end

endmodule
